ram_copy_dma: RTL
=================

Name: ram_copy_dma

Overview:
- Bus-initiator engine that drives the data-RAM port (memRead, memWrite, addr, writeData, readData) from the master side.
- Performs word block copy (src→dst) or block fill (constant→dst) over the 256 x 16-bit data memory.
- Sits beside the load/store path; the top-level muxes the RAM port to this block whenever busy=1.
- Used for memory init and stack/buffer moves without CPU instruction loops.

Parameters:
- ADDR_W, 8, RAM word-address width.
- DATA_W, 16, RAM word width.
- LEN_W, 9, transfer-length width; must hold 0..2^ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin transfer; sampled only in IDLE.
- mode  input  1  0 = copy, 1 = fill.
- src_addr  input  ADDR_W  copy source base (ignored in fill).
- dst_addr  input  ADDR_W  destination base.
- length  input  LEN_W  word count; 0 = no memory traffic.
- fill_value  input  DATA_W  word written in fill mode.
- abort  input  1  terminate transfer.
- busy  output  1  high in READ/WRITE states.
- done  output  1  one-cycle pulse on normal completion.
- aborted  output  1  one-cycle pulse on abort completion.
- words_done  output  LEN_W  words written so far in current/last transfer.
- memRead  output  1  RAM read enable.
- memWrite  output  1  RAM write enable.
- addr  output  ADDR_W  RAM address.
- writeData  output  DATA_W  RAM write data.
- readData  input  DATA_W  RAM read data; combinational, valid in the same cycle memRead=1.

Behaviour:
- Reset (async, immediate on rst high):
  - state=IDLE.
  - busy, done, aborted, memRead, memWrite = 0; addr, writeData, words_done = 0.
  - Internal src/dst pointers, remaining count and data buffer = 0.
- States: IDLE, READ, WRITE, FIN.
- RAM-port outputs are decoded from registered state/pointers only; no combinational path from any input to memRead, memWrite, addr or writeData.
- IDLE:
  - memRead=memWrite=0, addr=0, writeData=0.
  - On start=1 at posedge: latch mode, src, dst, length, fill_value; clear words_done.
  - length=0 → FIN (done pulse next cycle, zero RAM accesses).
  - length>0 → READ if copy, WRITE if fill.
- READ (copy only):
  - memRead=1, addr=src pointer.
  - At posedge: buf ← readData; src pointer +1 mod 256; → WRITE.
- WRITE:
  - memWrite=1, addr=dst pointer; writeData=buf (copy) or latched fill_value (fill).
  - At posedge: dst pointer +1 mod 256; words_done +1; remaining −1.
  - If remaining was 1 → FIN; else → READ (copy) or stay in WRITE (fill).
- FIN:
  - Exactly one cycle; done=1 (or aborted=1 if entered via abort); busy=0; RAM outputs idle; → IDLE.
- Throughput: copy 2 cycles/word, fill 1 cycle/word.
  - Start posedge to done pulse = 2·length+1 cycles (copy), length+1 cycles (fill); length=0 → 1.
- Address wrap: pointers wrap 0xFF→0x00 silently; length=256 touches every word once.
- Overlap: strict forward word order; each read sees all earlier writes of the same transfer. dst=src+1 therefore propagates mem[src] across the whole range. This is defined behaviour.
- start while busy or in FIN: ignored; no relatch.
- abort:
  - Sampled in READ/WRITE.
  - In WRITE, the write in that cycle still completes and is counted.
  - In READ, the read is discarded.
  - Next state FIN with aborted=1, done=0.
  - Ignored in IDLE/FIN.
- Simultaneous abort and last WRITE: aborted wins over done; words_done = length.
- words_done holds its value after FIN until the next accepted start.
- Reset mid-transfer: immediate return to IDLE with memWrite=0; any partial write in that cycle is not guaranteed.

Test Plan:
- Copy: preload RAM[0x10..0x12]=0xAAAA,0x1234,0xBEEF; start mode=0 src=0x10 dst=0x20 len=3 → RAM[0x20..0x22] match; done pulses exactly 7 cycles after start; words_done=3; busy high for 6 cycles.
- Fill wrap: mode=1 dst=0xFE len=4 fill=0x5A5A → RAM[0xFE],[0xFF],[0x00],[0x01]=0x5A5A; done after 5 cycles; RAM[0x02] unchanged.
- Zero length: len=0 → done 1 cycle after start; memRead/memWrite never asserted.
- Overlap: RAM[0x30]=0x0007, copy src=0x30 dst=0x31 len=4 → RAM[0x31..0x34] all 0x0007.
- Abort: copy len=10, assert abort in the 3rd WRITE cycle → aborted pulse, done=0, words_done=3, only 3 destination words modified.
- Start while busy plus async reset: pulse start mid-fill → no effect; assert rst mid-copy → all outputs 0 within the same cycle, state IDLE, a fresh start then works.

Source files
------------

// File: rtl/ram_copy_dma.sv
// Word block copy / fill engine that masters the data-RAM port.
// Copy moves one word every two cycles (read, write); fill writes one word per cycle.
module ram_copy_dma #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LEN_W  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic [DATA_W-1:0] fill_value,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [LEN_W-1:0]  words_done,
  output logic              memRead,
  output logic              memWrite,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] writeData,
  input  logic [DATA_W-1:0] readData
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StFin} state_e;

  state_e              state_q, state_d;
  logic                mode_q, mode_d;
  logic                abort_q, abort_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [LEN_W-1:0]    wcnt_q, wcnt_d;
  logic [DATA_W-1:0]   fill_q, fill_d;
  logic [DATA_W-1:0]   buf_q, buf_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      mode_q  <= 1'b0;
      abort_q <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      wcnt_q  <= '0;
      fill_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      abort_q <= abort_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      wcnt_q  <= wcnt_d;
      fill_q  <= fill_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    abort_d = abort_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    wcnt_d  = wcnt_q;
    fill_d  = fill_q;
    buf_d   = buf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mode_d  = mode;
          src_d   = src_addr;
          dst_d   = dst_addr;
          rem_d   = length;
          fill_d  = fill_value;
          wcnt_d  = '0;
          abort_d = 1'b0;
          if (length == '0) begin
            state_d = StFin;
          end else begin
            state_d = mode ? StWrite : StRead;
          end
        end
      end
      StRead: begin
        // An aborted read is simply dropped; nothing has been written for it yet.
        if (abort) begin
          abort_d = 1'b1;
          state_d = StFin;
        end else begin
          buf_d   = readData;
          src_d   = src_q + ADDR_W'(1);
          state_d = StWrite;
        end
      end
      StWrite: begin
        dst_d  = dst_q + ADDR_W'(1);
        wcnt_d = wcnt_q + LEN_W'(1);
        rem_d  = rem_q - LEN_W'(1);
        if (abort) begin
          abort_d = 1'b1;
          state_d = StFin;
        end else if (rem_q == LEN_W'(1)) begin
          state_d = StFin;
        end else begin
          state_d = mode_q ? StWrite : StRead;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // RAM port is decoded purely from registered state so no input reaches it combinationally.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    aborted   = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    addr      = '0;
    writeData = '0;
    unique case (state_q)
      StRead: begin
        busy    = 1'b1;
        memRead = 1'b1;
        addr    = src_q;
      end
      StWrite: begin
        busy      = 1'b1;
        memWrite  = 1'b1;
        addr      = dst_q;
        writeData = mode_q ? fill_q : buf_q;
      end
      StFin: begin
        done    = ~abort_q;
        aborted = abort_q;
      end
      default: begin
      end
    endcase
  end

  assign words_done = wcnt_q;

endmodule
